axi_s_pkt_filter: RTL and testbench

- Packet-granular classifier placed directly upstream of the inline dropper stage on the 64-bit packet AXI-Stream path.
- Inspects the first beat of each packet against a runtime mask/value pair.
- Forwards the whole packet through a one-deep registered output stage, or consumes and discards the whole packet.
- Keeps wrapping counters of passed and dropped packets.

---
 rtl/axi_s_pkt_filter.sv | 122 ++++++++++++
 tb/tb_axi_s_pkt_filter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_s_pkt_filter.sv
// axi_s_pkt_filter: packet-granular AXI-Stream classifier.
// Looks at the first beat of every packet and compares it with a runtime
// mask/value pair. Depending on the result, the whole packet is either
// forwarded through a one-deep registered output stage or swallowed.
// Wrapping counters record how many packets were passed and dropped.
module axi_s_pkt_filter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             filter_en,
   input  logic [63:0]      match_mask,
   input  logic [63:0]      match_value,
   input  logic             drop_on_match,
   input  logic [63:0]      s_packet_axis_tdata,
   input  logic             s_packet_axis_tvalid,
   input  logic             s_packet_axis_tlast,
   input  logic [7:0]       s_packet_axis_tkeep,
   output logic             s_packet_axis_tready,
   output logic [63:0]      m_packet_axis_tdata,
   output logic             m_packet_axis_tvalid,
   output logic             m_packet_axis_tlast,
   output logic [7:0]       m_packet_axis_tkeep,
   input  logic             m_packet_axis_tready,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   typedef enum logic [1:0] {HEAD, PASS, DROP} state_e;

   state_e           state_q;
   logic [63:0]      mTdata_q;
   logic             mTvalid_q;
   logic             mTlast_q;
   logic [7:0]       mTkeep_q;
   logic [CNT_W-1:0] passCnt_q;
   logic [CNT_W-1:0] dropCnt_q;

   logic             hit;
   logic             dropNow;
   logic             outSpace;
   logic             sReady;
   logic             accept;
   logic             loadOut;

   // Classification of the beat currently presented; only meaningful in HEAD,
   // so the control inputs are effectively sampled at the accepted first beat.
   always_comb begin
      hit      = ((s_packet_axis_tdata ^ match_value) & match_mask) == 64'd0;
      dropNow  = 1'b0;
      if (state_q == HEAD) begin
         dropNow = filter_en & (drop_on_match ? hit : !hit);
      end
   end

   // Input handshake: discards never wait on the output register, and the
   // port is held off while reset is asserted.
   always_comb begin
      outSpace = !mTvalid_q | m_packet_axis_tready;
      sReady   = 1'b0;
      case (state_q)
         HEAD:    sReady = dropNow | outSpace;
         PASS:    sReady = outSpace;
         DROP:    sReady = 1'b1;
         default: sReady = 1'b0;
      endcase
      sReady  = sReady & rst;
      accept  = s_packet_axis_tvalid & sReady;
      loadOut = accept & (((state_q == HEAD) & !dropNow) | (state_q == PASS));
   end

   // Packet FSM, registered output stage and pass/drop counters.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= HEAD;
         mTdata_q  <= '0;
         mTvalid_q <= 1'b0;
         mTlast_q  <= 1'b0;
         mTkeep_q  <= '0;
         passCnt_q <= '0;
         dropCnt_q <= '0;
      end else begin
         if (loadOut) begin
            mTdata_q  <= s_packet_axis_tdata;
            mTlast_q  <= s_packet_axis_tlast;
            mTkeep_q  <= s_packet_axis_tkeep;
            mTvalid_q <= 1'b1;
         end else if (m_packet_axis_tready) begin
            mTvalid_q <= 1'b0;
         end

         if (accept) begin
            case (state_q)
               HEAD: begin
                  if (dropNow) begin
                     dropCnt_q <= dropCnt_q + CNT_W'(1);
                     state_q   <= s_packet_axis_tlast ? HEAD : DROP;
                  end else begin
                     passCnt_q <= passCnt_q + CNT_W'(1);
                     state_q   <= s_packet_axis_tlast ? HEAD : PASS;
                  end
               end
               PASS, DROP: begin
                  if (s_packet_axis_tlast) begin
                     state_q <= HEAD;
                  end
               end
               default: state_q <= HEAD;
            endcase
         end
      end
   end

   assign s_packet_axis_tready = sReady;
   assign m_packet_axis_tdata  = mTdata_q;
   assign m_packet_axis_tvalid = mTvalid_q;
   assign m_packet_axis_tlast  = mTlast_q;
   assign m_packet_axis_tkeep  = mTkeep_q;
   assign pass_cnt             = passCnt_q;
   assign drop_cnt             = dropCnt_q;

endmodule

// File: tb/tb_axi_s_pkt_filter.sv
// Testbench for axi_s_pkt_filter: per-cycle vector table with expected
// outputs worked out by hand. Counters are narrowed so wrap-around is reachable.
module tb_axi_s_pkt_filter;

   localparam int CW = 3;

   logic          clk;
   logic          rst;
   logic          filterEn;
   logic [63:0]   matchMask;
   logic [63:0]   matchValue;
   logic          dropOnMatch;
   logic [63:0]   sTdata;
   logic          sTvalid;
   logic          sTlast;
   logic [7:0]    sTkeep;
   logic          sTready;
   logic [63:0]   mTdata;
   logic          mTvalid;
   logic          mTlast;
   logic [7:0]    mTkeep;
   logic          mTready;
   logic [CW-1:0] passCnt;
   logic [CW-1:0] dropCnt;

   typedef struct {
      logic          rst;
      logic          fen;
      logic          dom;
      logic [63:0]   val;
      logic [63:0]   data;
      logic          vld;
      logic          last;
      logic [7:0]    keep;
      logic          mrdy;
      logic          eSr;
      logic          eMv;
      logic          eChk;
      logic [63:0]   eMd;
      logic          eMl;
      logic [7:0]    eMk;
      logic [CW-1:0] ePc;
      logic [CW-1:0] eDc;
   } vec_t;

   vec_t vecs[$];
   int   checks;
   int   errors;
   int   curRow;

   axi_s_pkt_filter #(.CNT_W(CW)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .filter_en            (filterEn),
      .match_mask           (matchMask),
      .match_value          (matchValue),
      .drop_on_match        (dropOnMatch),
      .s_packet_axis_tdata  (sTdata),
      .s_packet_axis_tvalid (sTvalid),
      .s_packet_axis_tlast  (sTlast),
      .s_packet_axis_tkeep  (sTkeep),
      .s_packet_axis_tready (sTready),
      .m_packet_axis_tdata  (mTdata),
      .m_packet_axis_tvalid (mTvalid),
      .m_packet_axis_tlast  (mTlast),
      .m_packet_axis_tkeep  (mTkeep),
      .m_packet_axis_tready (mTready),
      .pass_cnt             (passCnt),
      .drop_cnt             (dropCnt)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic add(input logic r, input logic fen, input logic dom, input logic [63:0] val,
                      input logic [63:0] data, input logic vld, input logic last, input logic [7:0] keep,
                      input logic mrdy, input logic eSr, input logic eMv, input logic eChk,
                      input logic [63:0] eMd, input logic eMl, input logic [7:0] eMk,
                      input int ePc, input int eDc);
      vec_t v;
      v.rst = r;   v.fen = fen;   v.dom = dom;   v.val = val;
      v.data = data; v.vld = vld; v.last = last; v.keep = keep; v.mrdy = mrdy;
      v.eSr = eSr; v.eMv = eMv; v.eChk = eChk; v.eMd = eMd; v.eMl = eMl; v.eMk = eMk;
      v.ePc = CW'(ePc); v.eDc = CW'(eDc);
      vecs.push_back(v);
   endtask

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s row %0d: got %h expected %h", name, curRow, act, exp);
      end
   endtask

   // Drives one row's inputs on the falling edge; the rising edge that follows applies it.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      rst         = v.rst;
      filterEn    = v.fen;
      dropOnMatch = v.dom;
      matchValue  = v.val;
      sTdata      = v.data;
      sTvalid     = v.vld;
      sTlast      = v.last;
      sTkeep      = v.keep;
      mTready     = v.mrdy;
      #1;
   endtask

   task automatic checkOutput(input vec_t v);
      cmp("s_tready", 64'(sTready), 64'(v.eSr));
      cmp("m_tvalid", 64'(mTvalid), 64'(v.eMv));
      if (v.eChk) begin
         cmp("m_tdata", mTdata, v.eMd);
         cmp("m_tlast", 64'(mTlast), 64'(v.eMl));
         cmp("m_tkeep", 64'(mTkeep), 64'(v.eMk));
      end
      cmp("pass_cnt", 64'(passCnt), 64'(v.ePc));
      cmp("drop_cnt", 64'(dropCnt), 64'(v.eDc));
   endtask

   // Main sequence: reset check, then the vector table.
   initial begin
      checks = 0;
      errors = 0;
      curRow = -1;
      matchMask   = 64'h0000_0000_0000_FFFF;
      rst = 1'b0; filterEn = 1'b0; dropOnMatch = 1'b0; matchValue = '0;
      sTdata = 64'hDEAD; sTvalid = 1'b1; sTlast = 1'b0; sTkeep = 8'hFF; mTready = 1'b1;

      // Hand sequence: two reset cycles with a valid beat offered.
      repeat (2) @(posedge clk);
      @(negedge clk);
      cmp("reset s_tready", 64'(sTready), 64'd0);
      cmp("reset m_tvalid", 64'(mTvalid), 64'd0);
      cmp("reset m_tdata", mTdata, 64'd0);
      cmp("reset m_tlast", 64'(mTlast), 64'd0);
      cmp("reset m_tkeep", 64'(mTkeep), 64'd0);
      cmp("reset pass_cnt", 64'(passCnt), 64'd0);
      cmp("reset drop_cnt", 64'(dropCnt), 64'd0);

      // 3-beat packet, filter disabled
      add(1,0,0,64'h0,   64'hA0,1,0,8'hFF,1, 1,0,0,64'h0, 0,8'h00,0,0);
      add(1,0,0,64'h0,   64'hA1,1,0,8'hFF,1, 1,1,1,64'hA0,0,8'hFF,1,0);
      add(1,0,0,64'h0,   64'hA2,1,1,8'h0F,1, 1,1,1,64'hA1,0,8'hFF,1,0);
      add(1,0,0,64'h0,   64'h0, 0,0,8'hFF,1, 1,1,1,64'hA2,1,8'h0F,1,0);
      // drop_on_match: 4-beat matching packet dropped, then non-matching passes
      add(1,1,1,64'h0800,64'hB000_0000_0000_0800,1,0,8'hFF,1, 1,0,0,64'h0,0,8'h00,1,0);
      add(1,1,1,64'h0800,64'hB1,1,0,8'hFF,1, 1,0,0,64'h0,0,8'h00,1,1);
      add(1,1,1,64'h0800,64'hB2,1,0,8'hFF,0, 1,0,0,64'h0,0,8'h00,1,1);
      add(1,1,1,64'h0800,64'hB3,1,1,8'hFF,0, 1,0,0,64'h0,0,8'h00,1,1);
      add(1,1,1,64'h0800,64'hC000_0000_0000_86DD,1,1,8'h3F,1, 1,0,0,64'h0,0,8'h00,1,1);
      add(1,1,1,64'h0800,64'h0,0,0,8'hFF,1, 1,1,1,64'hC000_0000_0000_86DD,1,8'h3F,2,1);
      // pass only matching: single-beat 0x0800 forwarded, 0x0806 dropped
      add(1,1,0,64'h0800,64'hE000_0000_0000_0800,1,1,8'h01,1, 1,0,0,64'h0,0,8'h00,2,1);
      add(1,1,0,64'h0800,64'hF000_0000_0000_0806,1,1,8'hFF,1, 1,1,1,64'hE000_0000_0000_0800,1,8'h01,3,1);
      add(1,1,0,64'h0800,64'h0,0,0,8'hFF,1, 1,0,0,64'h0,0,8'h00,3,2);
      // 4-beat pass with output stalled for three cycles
      add(1,0,0,64'h0,   64'h60,1,0,8'hFF,1, 1,0,0,64'h0, 0,8'h00,3,2);
      add(1,0,0,64'h0,   64'h61,1,0,8'hFF,0, 0,1,1,64'h60,0,8'hFF,4,2);
      add(1,0,0,64'h0,   64'h61,1,0,8'hFF,0, 0,1,1,64'h60,0,8'hFF,4,2);
      add(1,0,0,64'h0,   64'h61,1,0,8'hFF,0, 0,1,1,64'h60,0,8'hFF,4,2);
      add(1,0,0,64'h0,   64'h61,1,0,8'hFF,1, 1,1,1,64'h60,0,8'hFF,4,2);
      add(1,0,0,64'h0,   64'h62,1,0,8'hFF,1, 1,1,1,64'h61,0,8'hFF,4,2);
      add(1,0,0,64'h0,   64'h63,1,1,8'hFF,1, 1,1,1,64'h62,0,8'hFF,4,2);
      add(1,0,0,64'h0,   64'h0, 0,0,8'hFF,1, 1,1,1,64'h63,1,8'hFF,4,2);
      add(1,0,0,64'h0,   64'h0, 0,0,8'hFF,1, 1,0,0,64'h0, 0,8'h00,4,2);
      // match_value changed mid-packet only affects the next header
      add(1,1,1,64'h0800,64'h7000_0000_0000_1234,1,0,8'hFF,1, 1,0,0,64'h0,0,8'h00,4,2);
      add(1,1,1,64'h1234,64'h7100_0000_0000_1234,1,1,8'hFF,1, 1,1,1,64'h7000_0000_0000_1234,0,8'hFF,5,2);
      add(1,1,1,64'h1234,64'h7200_0000_0000_1234,1,1,8'hFF,1, 1,1,1,64'h7100_0000_0000_1234,1,8'hFF,5,2);
      add(1,1,1,64'h1234,64'h0,0,0,8'hFF,1, 1,0,0,64'h0,0,8'h00,5,3);
      // reset in the middle of a passing packet; next beat is a header
      add(1,0,0,64'h0,   64'h80,1,0,8'hFF,1, 1,0,0,64'h0, 0,8'h00,5,3);
      add(1,0,0,64'h0,   64'h81,1,0,8'hFF,1, 1,1,1,64'h80,0,8'hFF,6,3);
      add(0,0,0,64'h0,   64'h82,1,0,8'hFF,1, 0,1,1,64'h81,0,8'hFF,6,3);
      add(1,1,1,64'h1234,64'h9000_0000_0000_1234,1,0,8'hFF,1, 1,0,1,64'h0,0,8'h00,0,0);
      add(1,1,1,64'h1234,64'h91,1,1,8'hFF,1, 1,0,0,64'h0,0,8'h00,0,1);
      add(1,1,1,64'h1234,64'h0, 0,0,8'hFF,1, 1,0,0,64'h0,0,8'h00,0,1);
      // dropped packet consumed while a passed beat sits stalled in the output
      add(1,1,1,64'h1234,64'hD000_0000_0000_0001,1,1,8'hFF,0, 1,0,0,64'h0,0,8'h00,0,1);
      add(1,1,1,64'h1234,64'hD100_0000_0000_1234,1,0,8'hFF,0, 1,1,1,64'hD000_0000_0000_0001,1,8'hFF,1,1);
      add(1,1,1,64'h1234,64'hD2,1,1,8'hFF,0, 1,1,1,64'hD000_0000_0000_0001,1,8'hFF,1,2);
      add(1,1,1,64'h1234,64'hD300_0000_0000_0002,1,1,8'hAA,0, 0,1,1,64'hD000_0000_0000_0001,1,8'hFF,1,2);
      add(1,1,1,64'h1234,64'hD300_0000_0000_0002,1,1,8'hAA,1, 1,1,1,64'hD000_0000_0000_0001,1,8'hFF,1,2);
      add(1,1,1,64'h1234,64'h0,0,0,8'hFF,1, 1,1,1,64'hD300_0000_0000_0002,1,8'hAA,2,2);
      // back-to-back single-beat packets, pass counter wraps past 2^CW
      for (int i = 0; i < 6; i++) begin
         add(1,0,0,64'h0, 64'hE0 + 64'(i),1,1,8'hFF,1,
             1,(i > 0),(i > 0),64'hE0 + 64'(i) - 64'd1,1,8'hFF,(2 + i) % 8,2);
      end
      add(1,0,0,64'h0, 64'h0,0,0,8'hFF,1, 1,1,1,64'hE5,1,8'hFF,0,2);

      for (int r = 0; r < vecs.size(); r++) begin
         curRow = r;
         applyStimulus(vecs[r]);
         checkOutput(vecs[r]);
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
